// File: rtl/pending_req_arbiter.sv
// pending_req_arbiter
//
// Latches single-cycle request pulses from IN_SIZE sources into a sticky
// pending vector. It grants the highest-index pending source through a
// registered valid/ready output, and each request is retired exactly once
// when it is accepted.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous, active-high reset
//   req_in     per-source request pulses (one cycle high = one event)
//   out_valid  out_idx holds an unserviced source index
//   out_ready  consumer accepts out_idx when out_valid & out_ready
//   out_idx    index of the granted source
//   pending    pending vector; excludes the source held in the output register
//   drop_cnt   saturating count of cycles with at least one merged event
//
// Build option:
//   PENDING_REQ_ARBITER_DROP_CNT_EN  defined: drop_cnt counts drop cycles and
//                                    saturates at all-ones.
//                                    undefined: drop_cnt is tied to zero.
//
// State table:
//   state | meaning
//   EMPTY | output register holds nothing, out_valid = 0
//   FULL  | output register holds a granted index, out_valid = 1

module pending_req_arbiter #(
    parameter int IN_SIZE  = 8,
    parameter int OUT_SIZE = $clog2(IN_SIZE),
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IN_SIZE-1:0]  req_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_SIZE-1:0] out_idx,
    output logic [IN_SIZE-1:0]  pending,
    output logic [CNT_W-1:0]    drop_cnt
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t              state;
    logic [OUT_SIZE-1:0] sel_idx;
    logic                any_pend;
    logic                load;
    logic [IN_SIZE-1:0]  xfer_mask;
    logic [IN_SIZE-1:0]  pending_next;

    // Highest set index wins: later loop iterations override earlier ones.
    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < IN_SIZE; i++) begin
            if (pending[i]) begin
                sel_idx = OUT_SIZE'(i);
            end
        end
    end

    assign any_pend = |pending;

    // The output register loads whenever it is free or being emptied this cycle.
    assign load      = any_pend && ((state == EMPTY) || out_ready);
    assign xfer_mask = load ? (IN_SIZE'(1) << sel_idx) : '0;

    // OR-ing req_in last makes a new event win over the transfer of the same bit.
    assign pending_next = (pending & ~xfer_mask) | req_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            out_idx   <= '0;
            pending   <= '0;
        end else begin
            pending <= pending_next;
            case (state)
                EMPTY: begin
                    if (any_pend) begin
                        out_idx   <= sel_idx;
                        out_valid <= 1'b1;
                        state     <= FULL;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        if (any_pend) begin
                            out_idx <= sel_idx;
                        end else begin
                            out_valid <= 1'b0;
                            state     <= EMPTY;
                        end
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= EMPTY;
                end
            endcase
        end
    end

`ifdef PENDING_REQ_ARBITER_DROP_CNT_EN
    logic drop;

    // An event merges into an existing one when its bit is already pending and
    // that bit is not leaving for the output register this cycle.
    assign drop = |(req_in & pending & ~xfer_mask);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != {CNT_W{1'b1}})) begin
            drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_pending_req_arbiter.sv
module tb_pending_req_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] req_in;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_idx;
    logic [7:0] pending;
    logic [7:0] drop_cnt;

    int total = 0;
    int bad   = 0;

`ifdef PENDING_REQ_ARBITER_DROP_CNT_EN
    localparam logic [7:0] D1 = 8'd1;
    localparam logic [7:0] D2 = 8'd2;
`else
    localparam logic [7:0] D1 = 8'd0;
    localparam logic [7:0] D2 = 8'd0;
`endif

    typedef struct {
        logic [7:0] req;
        logic       rdy;
        logic       ev;
        logic [2:0] ei;
        logic [7:0] ep;
        logic [7:0] ed;
    } vec_t;

    vec_t vecs[$];

    pending_req_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .req_in   (req_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_idx  (out_idx),
        .pending  (pending),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [7:0] req, input logic rdy, input logic ev,
                       input logic [2:0] ei, input logic [7:0] ep, input logic [7:0] ed);
        vec_t v;
        v.req = req; v.rdy = rdy; v.ev = ev; v.ei = ei; v.ep = ep; v.ed = ed;
        vecs.push_back(v);
    endtask

    task automatic chk_all(input string tag, input logic ev, input logic [2:0] ei,
                           input logic [7:0] ep, input logic [7:0] ed);
        chk({tag, " valid"}, 32'(out_valid), 32'(ev));
        chk({tag, " pending"}, 32'(pending), 32'(ep));
        chk({tag, " drop_cnt"}, 32'(drop_cnt), 32'(ed));
        if (ev) chk({tag, " idx"}, 32'(out_idx), 32'(ei));
    endtask

    initial begin
        // Each row: inputs applied at a falling edge, outputs expected after the
        // following rising edge (checked at the next falling edge).
        // idle
        for (int i = 0; i < 5; i++) add(8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 8'd0);
        // single pulse, ready high
        add(8'h10, 1'b1, 1'b0, 3'd0, 8'h10, 8'd0);
        add(8'h00, 1'b1, 1'b1, 3'd4, 8'h00, 8'd0);
        add(8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 8'd0);
        // 8'h85 with stall, then drain 7, 2, 0
        add(8'h85, 1'b0, 1'b0, 3'd0, 8'h85, 8'd0);
        add(8'h00, 1'b0, 1'b1, 3'd7, 8'h05, 8'd0);
        add(8'h00, 1'b0, 1'b1, 3'd7, 8'h05, 8'd0);
        add(8'h00, 1'b0, 1'b1, 3'd7, 8'h05, 8'd0);
        add(8'h00, 1'b1, 1'b1, 3'd2, 8'h01, 8'd0);
        add(8'h00, 1'b1, 1'b1, 3'd0, 8'h00, 8'd0);
        add(8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 8'd0);
        // drops: index 6 held stalled, index 3 pending, pulsed twice more
        add(8'h40, 1'b0, 1'b0, 3'd0, 8'h40, 8'd0);
        add(8'h08, 1'b0, 1'b1, 3'd6, 8'h08, 8'd0);
        add(8'h08, 1'b0, 1'b1, 3'd6, 8'h08, D1);
        add(8'h08, 1'b0, 1'b1, 3'd6, 8'h08, D2);
        add(8'h00, 1'b1, 1'b1, 3'd3, 8'h00, D2);
        add(8'h00, 1'b1, 1'b0, 3'd0, 8'h00, D2);
        add(8'h00, 1'b1, 1'b0, 3'd0, 8'h00, D2);
        // set coinciding with transfer of index 5: granted twice, no drop
        add(8'h20, 1'b1, 1'b0, 3'd0, 8'h20, D2);
        add(8'h20, 1'b1, 1'b1, 3'd5, 8'h20, D2);
        add(8'h00, 1'b1, 1'b1, 3'd5, 8'h00, D2);
        add(8'h00, 1'b1, 1'b0, 3'd0, 8'h00, D2);

        rst = 1'b1;
        req_in = 8'h00;
        out_ready = 1'b0;
        #2;
        chk_all("reset_async", 1'b0, 3'd0, 8'h00, 8'd0);
        chk("reset_async idx", 32'(out_idx), 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk_all("reset_held", 1'b0, 3'd0, 8'h00, 8'd0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            req_in = vecs[i].req;
            out_ready = vecs[i].rdy;
            @(negedge clk);
            chk_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ei, vecs[i].ep, vecs[i].ed);
        end

        // Reset while a grant is held with pending = 8'h3C.
        req_in = 8'h7C;
        out_ready = 1'b0;
        @(negedge clk);
        req_in = 8'h00;
        @(negedge clk);
        chk_all("pre_rst", 1'b1, 3'd6, 8'h3C, D2);
        #1 rst = 1'b1;
        #1;
        chk_all("mid_rst_async", 1'b0, 3'd0, 8'h00, 8'd0);
        chk("mid_rst_async idx", 32'(out_idx), 32'd0);
        @(negedge clk);
        chk_all("mid_rst_held", 1'b0, 3'd0, 8'h00, 8'd0);
        chk("mid_rst_held idx", 32'(out_idx), 32'd0);
        rst = 1'b0;
        req_in = 8'h01;
        out_ready = 1'b1;
        @(negedge clk);
        req_in = 8'h00;
        chk_all("post_rst_p1", 1'b0, 3'd0, 8'h01, 8'd0);
        @(negedge clk);
        chk_all("post_rst_p2", 1'b1, 3'd0, 8'h00, 8'd0);
        @(negedge clk);
        chk_all("post_rst_p3", 1'b0, 3'd0, 8'h00, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pending_req_arbiter.md
# pending_req_arbiter

Sequential front end for the parameterized priority encoder. It latches single-cycle request pulses from `IN_SIZE` sources into a sticky pending vector and resolves the highest-index pending source through the encoder's priority rule. It presents that source's index on a registered valid/ready output and retires each request exactly once when it is accepted. It sits between raw event sources (interrupt lines, channel done strobes) and a consumer that services one source at a time.

## Interface
- `IN_SIZE`, default 8: number of request sources; legal range ≥ 2.
- `OUT_SIZE`, default `$clog2(IN_SIZE)`: index width.
- `CNT_W`, default 8: drop counter width.

- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_in`  in  IN_SIZE  per-source request pulses; a bit high for one cycle is one event.
- `out_valid`  out  1  `out_idx` holds an unserviced source index.
- `out_ready`  in  1  consumer accepts `out_idx` when `out_valid & out_ready`.
- `out_idx`  out  OUT_SIZE  index of the granted source.
- `pending`  out  IN_SIZE  registered pending vector. It excludes the source currently held in the output register.
- `drop_cnt`  out  CNT_W  saturating count of cycles in which at least one event was dropped.

## Operation
- Pending update each cycle: `pending_next = (pending & ~xfer_mask) | req_in`.
  - `xfer_mask` is the one-hot of the index loaded into the output register this cycle, or zero if no load occurs.
- Selection rule: the highest set index of the registered `pending` wins. Index 0 has the lowest priority. This matches the priority encoder's rule.
- FSM has two states: EMPTY (`out_valid`=0) and FULL (`out_valid`=1).
  - EMPTY with `|pending`: load `out_idx` with the selected index, clear that pending bit, and go to FULL.
  - EMPTY with no pending bits: stay in EMPTY.
  - FULL with `out_ready` and `|pending`: handshake completes; reload in the same cycle with the newly selected index and stay in FULL.
  - FULL with `out_ready` and no pending bits: go to EMPTY.
  - FULL with `!out_ready`: hold `out_idx` stable. `pending` keeps accumulating.
- Simultaneous events:
  - If `req_in[k]` coincides with the transfer of bit k, the set wins. The new event stays pending and is not a drop.
  - A new `req_in[k]` while index k sits in the output register is a new event. It sets `pending[k]` normally.
- Drop:
  - A drop is `req_in[k]` asserted while `pending[k]` is already 1 and bit k is not being transferred that cycle. The event merges into the existing one.
  - Multiple drops in one cycle count as one.
- Reset mid-operation:
  - `pending`, `out_valid`, `out_idx`, and `drop_cnt` clear immediately and asynchronously.
  - Any held grant is lost without handshake.
  - `req_in` in the first cycle after `rst` deasserts is captured normally.

## Timing
- Reset values: `out_valid`=0, `out_idx`=0, `pending`=0, `drop_cnt`=0.
- Latency: `req_in` at cycle N gives `pending` at N+1. It gives `out_valid`/`out_idx` at N+2 if the FSM is EMPTY at N+1.
- Throughput: one grant per cycle with `out_ready` held high and sources pending.
- `out_idx` and `out_valid` are registered outputs, with no combinational path from `req_in` or `out_ready`.
- `out_idx` must not change while `out_valid & !out_ready`.

## Configuration
- Macro: `PENDING_REQ_ARBITER_DROP_CNT_EN`.
- Defined: `drop_cnt` increments by 1 on each cycle with at least one drop and saturates at all-ones.
- Undefined: no counter logic is built and `drop_cnt` is tied to 0.
- The port list is identical in both builds.

## Test plan
- Reset, then `req_in`=8'h00 for 5 cycles: `out_valid`=0, `pending`=0, and `drop_cnt`=0 throughout.
- Single pulse `req_in`=8'h10 at cycle N with `out_ready`=1:
  - `pending`=8'h10 at N+1.
  - At N+2, `out_valid`=1 and `out_idx`=4; the handshake occurs at N+2.
  - `out_valid`=0 at N+3.
- Pulse `req_in`=8'h85 with `out_ready`=0 for 3 cycles, then 1:
  - First `out_idx`=7, which holds stable while stalled, with `pending`=8'h05.
  - Then grants follow 2, then 0, on consecutive cycles, and then `out_valid`=0.
- With `out_ready`=0 and `pending[3]`=1, pulse `req_in`=8'h08 twice more:
  - `pending` stays 8'h08; `drop_cnt`=2 with the macro and 0 without it.
  - Exactly one grant of index 3 follows.
- `req_in[5]` pulses in the same cycle index 5 loads into the output register: `pending[5]`=1 next cycle and no drop. Index 5 is granted twice in total.
- Assert `rst` for 1 cycle while `out_valid`=1 and `pending`=8'h3C: all outputs read 0 during `rst`. A pulse `req_in`=8'h01 right after release yields `out_idx`=0 two cycles later.
